spi_mult_sequencer: RTL and testbench
=====================================

Name: spi_mult_sequencer

Overview:
- Transaction controller for the SPI multiplier peripheral. It sequences one chip-select frame:
  1. Shift in two packed operands.
  2. Pulse the multiplier start.
  3. Wait for the multiplier's done.
  4. Parallel-load the product into the shift register.
  5. Shift the product out with the MISO buffer enabled.
- It replaces the ad-hoc peripheral FSM. It drives the shift register mode and the multiplier start, and consumes conditioned SCLK edge pulses and the multiplier's done.

Parameters:
- OP_WIDTH, 4, operand width. One frame is FRAME = 2*OP_WIDTH bits in and FRAME bits out.
- MULT_TIMEOUT, 32, clk cycles allowed in WAIT before timeout (used only with the optional feature).

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- rst_n  input  1  synchronous active-low reset
- cs_n  input  1  conditioned chip select, active low
- sclk_pe  input  1  one-clk pulse on each conditioned SCLK rising edge
- mult_done  input  1  multiplier result valid; level or pulse
- sr_mode  output  2  shift register mode: 00 HOLD, 01 SHIFT (shifts on sclk_pe), 10 PLOAD, 11 unused
- mult_start  output  1  one-clk start pulse to the multiplier
- miso_en  output  1  MISO output buffer enable
- busy  output  1  high in every state except IDLE
- err_timeout  output  1  sticky multiplier-timeout flag

Behaviour:
- Moore FSM. All outputs are registered and decoded from the state only.
- States: IDLE, RX, START, WAIT, LOAD, TX, DONE, ERR.
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, bit_cnt=0, wait_cnt=0.
  - sr_mode=00, mult_start=0, miso_en=0, busy=0, err_timeout=0.
  - Reset overrides every other event, including mid-frame.
- IDLE:
  - Outputs: sr_mode=00.
  - Transition: cs_n=0 -> RX, bit_cnt cleared to 0.
- RX:
  - Outputs: sr_mode=01.
  - Each sclk_pe increments bit_cnt.
  - Transition: sclk_pe while bit_cnt==FRAME-1 -> START. The last bit is shifted in the same cycle.
- START:
  - Outputs: mult_start=1 for exactly one cycle, sr_mode=00.
  - Transition: unconditionally -> WAIT, wait_cnt cleared.
- WAIT:
  - Outputs: sr_mode=00.
  - Transition: mult_done=1 -> LOAD.
  - sclk_pe pulses are ignored; the shift register holds.
- LOAD:
  - Outputs: sr_mode=10 for exactly one cycle.
  - Transition: -> TX, bit_cnt cleared.
- TX:
  - Outputs: sr_mode=01, miso_en=1.
  - Each sclk_pe increments bit_cnt.
  - Transition: sclk_pe while bit_cnt==FRAME-1 -> DONE.
- DONE:
  - Outputs: sr_mode=00, miso_en=0.
  - Further sclk_pe pulses are ignored. Remain until cs_n=1.
- ERR:
  - Outputs: sr_mode=00, miso_en=0, err_timeout=1.
  - Remain until cs_n=1.
- Abort:
  - cs_n=1 in any non-IDLE state -> IDLE on the next edge.
  - Abort has priority over any simultaneous sclk_pe or mult_done.
  - Outputs return to IDLE values; no mult_start is issued.
  - err_timeout is not cleared by abort.
- err_timeout clears on entry to RX (the next frame) or on reset.
- Latency:
  - Last RX sclk_pe -> mult_start high on the next cycle.
  - mult_done -> sr_mode=10 on the next cycle.
  - TX begins the cycle after LOAD.
- Counters:
  - bit_cnt width is clog2(FRAME)+1 and never wraps within a frame.
  - wait_cnt saturates at MULT_TIMEOUT.
- mult_done sampled outside WAIT is ignored.

Optional Feature:
- Macro: SPI_MULT_TIMEOUT_EN.
- Defined:
  - wait_cnt increments each clk in WAIT.
  - If wait_cnt reaches MULT_TIMEOUT-1 with mult_done=0 -> ERR.
  - mult_done on that same cycle wins -> LOAD.
- Undefined:
  - No wait_cnt; WAIT lasts indefinitely until mult_done or abort.
  - ERR is unreachable and err_timeout is tied to 0.

Test Plan:
1. Nominal frame, OP_WIDTH=4:
   - Stimulus: cs_n low, 8 sclk_pe pulses shifting 0x35, mult_done 5 clks after start.
   - Response: mult_start high for 1 clk, one clk after the 8th pulse; sr_mode=10 for 1 clk, one clk after done; miso_en=1 through 8 TX pulses; then DONE with miso_en=0; IDLE after cs_n high.
2. Abort in RX:
   - Stimulus: cs_n rises after 3 sclk_pe.
   - Response: IDLE next clk; mult_start never asserts; sr_mode=00, busy=0.
3. Simultaneous events:
   - Stimulus: cs_n rises in the same clk as the 8th RX sclk_pe.
   - Response: IDLE; no mult_start.
4. Spurious SCLK in WAIT:
   - Stimulus: 4 sclk_pe pulses during WAIT, then mult_done.
   - Response: sr_mode stays 00 throughout WAIT; TX still requires 8 pulses.
5. Timeout with SPI_MULT_TIMEOUT_EN, MULT_TIMEOUT=32:
   - Stimulus: mult_done held 0.
   - Response: ERR and err_timeout=1 exactly 32 clks after entering WAIT; miso_en=0.
   - Next frame: err_timeout clears on RX entry.
   - Without the macro: still in WAIT after 1000 clks.
6. Reset mid-TX:
   - Stimulus: rst_n=0 for 1 clk after 3 TX pulses.
   - Response: all outputs at reset values next clk; a new cs_n low then starts RX with bit_cnt=0.

Source files
------------

// File: rtl/spi_mult_sequencer_if.sv
// ---------------------------------------------------------------------------
// spi_mult_sequencer_if
// Bundles the frame-control signals between the SPI multiplier sequencer and
// its surroundings (SCLK/CS conditioner, shift register, multiplier).
//
// Signals:
//   cs_n        conditioned chip select, active low          (to sequencer)
//   sclk_pe     one-clk pulse per conditioned SCLK rise        (to sequencer)
//   mult_done   multiplier result valid, level or pulse        (to sequencer)
//   sr_mode     shift register mode 00 HOLD/01 SHIFT/10 PLOAD  (from sequencer)
//   mult_start  one-clk multiplier start pulse                 (from sequencer)
//   miso_en     MISO output buffer enable                      (from sequencer)
//   busy        high whenever the sequencer is not idle        (from sequencer)
//   err_timeout sticky multiplier-timeout flag                 (from sequencer)
//   state_dbg   current FSM state encoding, for observation    (from sequencer)
//
// Handshake: there is no valid/ready pair here. Every input is sampled on the
// rising clk edge; sclk_pe and mult_done are acted on only in the states that
// consume them, and cs_n high always returns the sequencer to idle.
//
// Modports: slave = sequencer side, master = driving environment.
// ---------------------------------------------------------------------------
interface spi_mult_sequencer_if;
  logic       cs_n;
  logic       sclk_pe;
  logic       mult_done;
  logic [1:0] sr_mode;
  logic       mult_start;
  logic       miso_en;
  logic       busy;
  logic       err_timeout;
  logic [2:0] state_dbg;

  modport slave (
    input  cs_n, sclk_pe, mult_done,
    output sr_mode, mult_start, miso_en, busy, err_timeout, state_dbg
  );

  modport master (
    output cs_n, sclk_pe, mult_done,
    input  sr_mode, mult_start, miso_en, busy, err_timeout, state_dbg
  );
endinterface

// File: rtl/spi_mult_sequencer.sv
// ---------------------------------------------------------------------------
// spi_mult_sequencer
// Transaction controller for the SPI multiplier peripheral. Within one
// chip-select frame it shifts in two packed operands, pulses the multiplier
// start, waits for done, parallel-loads the product and shifts it out with
// the MISO buffer enabled.
//
// Ports:
//   clk     system clock, all state changes on the rising edge
//   rst_n   synchronous active-low reset
//   io_bus  spi_mult_sequencer_if.slave (cs_n, sclk_pe, mult_done in;
//           sr_mode, mult_start, miso_en, busy, err_timeout, state_dbg out)
//
// Parameters:
//   OP_WIDTH      operand width; a frame is FRAME = 2*OP_WIDTH bits each way
//   MULT_TIMEOUT  clk cycles allowed in WAIT (timeout build only)
//
// Optional feature macro: SPI_MULT_TIMEOUT_EN
//   Defined   : WAIT counts clocks; no done by MULT_TIMEOUT cycles -> ERR.
//   Undefined : WAIT lasts until done or abort; err_timeout tied low.
//
// All outputs are registers loaded from a decode of the next state, so each
// output is a pure function of the state it is presented alongside.
// ---------------------------------------------------------------------------
module spi_mult_sequencer #(
  parameter int OP_WIDTH     = 4,
  parameter int MULT_TIMEOUT = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  spi_mult_sequencer_if.slave   io_bus
);

  localparam int FRAME = 2 * OP_WIDTH;
  localparam int CNT_W = $clog2(FRAME) + 1;

  localparam logic [1:0] SR_HOLD  = 2'b00;
  localparam logic [1:0] SR_SHIFT = 2'b01;
  localparam logic [1:0] SR_PLOAD = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RX    = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_LOAD  = 3'd4,
    S_TX    = 3'd5,
    S_DONE  = 3'd6,
    S_ERR   = 3'd7
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [CNT_W-1:0] w_bit_cnt_nxt;

  logic [1:0]       r_sr_mode;
  logic             r_mult_start;
  logic             r_miso_en;
  logic             r_busy;
  logic             r_err_timeout;

  logic [1:0]       w_sr_mode_nxt;
  logic             w_last_bit;

`ifdef SPI_MULT_TIMEOUT_EN
  localparam int WAIT_W = $clog2(MULT_TIMEOUT + 1);
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_cnt_nxt;
`endif

  // The frame's final bit: sclk_pe arriving with bit_cnt at FRAME-1.
  assign w_last_bit = io_bus.sclk_pe && (r_bit_cnt == CNT_W'(FRAME - 1));

  // -------------------------------------------------------------------------
  // Next-state and counter logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_next_state  = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
`ifdef SPI_MULT_TIMEOUT_EN
    w_wait_cnt_nxt = r_wait_cnt;
`endif

    // cs_n deasserted aborts every non-idle state and outranks sclk_pe and
    // mult_done arriving in the same cycle.
    if ((r_state != S_IDLE) && io_bus.cs_n) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!io_bus.cs_n) begin
            w_next_state  = S_RX;
            w_bit_cnt_nxt = '0;
          end
        end

        S_RX: begin
          if (io_bus.sclk_pe) begin
            // Counter is one bit wider than needed to index FRAME, so this
            // increment cannot wrap inside a frame.
            w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
            if (w_last_bit) begin
              w_next_state = S_START;
            end
          end
        end

        S_START: begin
          w_next_state = S_WAIT;
`ifdef SPI_MULT_TIMEOUT_EN
          w_wait_cnt_nxt = '0;
`endif
        end

        S_WAIT: begin
`ifdef SPI_MULT_TIMEOUT_EN
          if (r_wait_cnt != WAIT_W'(MULT_TIMEOUT)) begin
            w_wait_cnt_nxt = r_wait_cnt + WAIT_W'(1);
          end
          // A done landing on the timeout cycle still wins.
          if (io_bus.mult_done) begin
            w_next_state = S_LOAD;
          end else if (r_wait_cnt >= WAIT_W'(MULT_TIMEOUT - 1)) begin
            w_next_state = S_ERR;
          end
`else
          if (io_bus.mult_done) begin
            w_next_state = S_LOAD;
          end
`endif
        end

        S_LOAD: begin
          w_next_state  = S_TX;
          w_bit_cnt_nxt = '0;
        end

        S_TX: begin
          if (io_bus.sclk_pe) begin
            w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
            if (w_last_bit) begin
              w_next_state = S_DONE;
            end
          end
        end

        // DONE and ERR park until cs_n rises (handled by the abort branch).
        S_DONE:  w_next_state = S_DONE;
        S_ERR:   w_next_state = S_ERR;
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  // Shift-register mode decode for the state being entered.
  always_comb begin
    w_sr_mode_nxt = SR_HOLD;
    case (w_next_state)
      S_RX, S_TX: w_sr_mode_nxt = SR_SHIFT;
      S_LOAD:     w_sr_mode_nxt = SR_PLOAD;
      default:    w_sr_mode_nxt = SR_HOLD;
    endcase
  end

  // -------------------------------------------------------------------------
  // State, counters and registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_bit_cnt    <= '0;
      r_sr_mode    <= SR_HOLD;
      r_mult_start <= 1'b0;
      r_miso_en    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_sr_mode    <= w_sr_mode_nxt;
      r_mult_start <= (w_next_state == S_START);
      r_miso_en    <= (w_next_state == S_TX);
      r_busy       <= (w_next_state != S_IDLE);
    end
  end

`ifdef SPI_MULT_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
    end else begin
      r_wait_cnt <= w_wait_cnt_nxt;
    end
  end

  // Sticky: set on entering ERR, survives the abort back to IDLE, and is
  // cleared only when the next frame enters RX.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err_timeout <= 1'b0;
    end else if (w_next_state == S_ERR) begin
      r_err_timeout <= 1'b1;
    end else if ((r_state == S_IDLE) && (w_next_state == S_RX)) begin
      r_err_timeout <= 1'b0;
    end
  end
`else
  always_ff @(posedge clk) begin
    r_err_timeout <= 1'b0;
  end
`endif

  assign io_bus.sr_mode     = r_sr_mode;
  assign io_bus.mult_start  = r_mult_start;
  assign io_bus.miso_en     = r_miso_en;
  assign io_bus.busy        = r_busy;
  assign io_bus.err_timeout = r_err_timeout;
  assign io_bus.state_dbg   = r_state;

endmodule

// File: tb/tb_spi_mult_sequencer.sv
// ---------------------------------------------------------------------------
// tb_spi_mult_sequencer
// Directed bench for spi_mult_sequencer (OP_WIDTH=4, MULT_TIMEOUT=32).
// The driver pushes each expected output-vector change into exp_q before
// causing it; the monitor pops and compares whenever the DUT outputs change.
// Output vector = {busy, err_timeout, miso_en, mult_start, sr_mode[1:0]}.
// ---------------------------------------------------------------------------
module tb_spi_mult_sequencer;

  localparam int OP_WIDTH     = 4;
  localparam int MULT_TIMEOUT = 32;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RX    = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_TX    = 3'd5;
  localparam logic [2:0] ST_DONE  = 3'd6;
  localparam logic [2:0] ST_ERR   = 3'd7;

  localparam logic [5:0] E_IDLE     = 6'b000000;
  localparam logic [5:0] E_RX       = 6'b100001;
  localparam logic [5:0] E_START    = 6'b100100;
  localparam logic [5:0] E_WAIT     = 6'b100000;
  localparam logic [5:0] E_LOAD     = 6'b100010;
  localparam logic [5:0] E_TX       = 6'b101001;
  localparam logic [5:0] E_DONE     = 6'b100000;
  localparam logic [5:0] E_ERR      = 6'b110000;
  localparam logic [5:0] E_IDLE_ERR = 6'b010000;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_mult_sequencer_if bus ();

  spi_mult_sequencer #(
    .OP_WIDTH     (OP_WIDTH),
    .MULT_TIMEOUT (MULT_TIMEOUT)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  // ---------------- scoreboard state ----------------
  int         checks    = 0;
  int         failures  = 0;
  int         start_cnt = 0;
  logic [5:0] exp_q[$];
  logic [5:0] last_out;
  logic [5:0] mon_cur;
  logic [5:0] mon_exp;
  logic       mon_en = 1'b0;

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.mult_start === 1'b1) start_cnt++;
      mon_cur = {bus.busy, bus.err_timeout, bus.miso_en, bus.mult_start, bus.sr_mode};
      if (mon_cur !== last_out) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL out_change act=%b exp=no_change t=%0t", mon_cur, $time);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_cur !== mon_exp) begin
            failures++;
            $display("FAIL out_change act=%b exp=%b t=%0t", mon_cur, mon_exp, $time);
          end
        end
        last_out = mon_cur;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      bus.sclk_pe = 1'b1;
      tick();
      bus.sclk_pe = 1'b0;
      tick();
    end
  endtask

  // Open a frame, shift a full operand pair and land in WAIT.
  task automatic to_wait();
    exp_q.push_back(E_RX);
    bus.cs_n = 1'b0;
    tick();
    pulses(7);
    exp_q.push_back(E_START);
    bus.sclk_pe = 1'b1;
    tick();
    bus.sclk_pe = 1'b0;
    exp_q.push_back(E_WAIT);
    tick();
  endtask

  task automatic done_to_tx();
    bus.mult_done = 1'b1;
    exp_q.push_back(E_LOAD);
    tick();
    bus.mult_done = 1'b0;
    exp_q.push_back(E_TX);
    tick();
  endtask

  int s0;

  // ---------------- stimulus ----------------
  initial begin
    bus.cs_n      = 1'b1;
    bus.sclk_pe   = 1'b0;
    bus.mult_done = 1'b0;
    rst_n         = 1'b0;
    tick();
    tick();
    check("reset_outputs", {bus.busy, bus.err_timeout, bus.miso_en, bus.mult_start, bus.sr_mode}, 6'b0);
    check("reset_state", bus.state_dbg, ST_IDLE);
    rst_n    = 1'b1;
    last_out = 6'b0;
    mon_en   = 1'b1;
    tick();

    // 1. Nominal frame (operand byte 0x35 is carried by the shift register).
    exp_q.push_back(E_RX);
    bus.cs_n = 1'b0;
    tick();
    check("t1_rx_entry", bus.state_dbg, ST_RX);
    pulses(7);
    check("t1_rx_after7", bus.state_dbg, ST_RX);
    exp_q.push_back(E_START);
    bus.sclk_pe = 1'b1;
    tick();
    bus.sclk_pe = 1'b0;
    check("t1_start_latency", bus.mult_start, 1'b1);
    exp_q.push_back(E_WAIT);
    tick();
    check("t1_start_one_clk", bus.mult_start, 1'b0);
    repeat (4) tick();
    bus.mult_done = 1'b1;
    exp_q.push_back(E_LOAD);
    tick();
    bus.mult_done = 1'b0;
    check("t1_pload", bus.sr_mode, 2'b10);
    exp_q.push_back(E_TX);
    tick();
    check("t1_tx_miso", bus.miso_en, 1'b1);
    pulses(7);
    check("t1_tx_after7", bus.state_dbg, ST_TX);
    exp_q.push_back(E_DONE);
    bus.sclk_pe = 1'b1;
    tick();
    bus.sclk_pe = 1'b0;
    check("t1_done_state", bus.state_dbg, ST_DONE);
    check("t1_done_miso", bus.miso_en, 1'b0);
    pulses(2);
    check("t1_done_ignores_sclk", bus.state_dbg, ST_DONE);
    exp_q.push_back(E_IDLE);
    bus.cs_n = 1'b1;
    tick();
    check("t1_idle_busy", bus.busy, 1'b0);
    tick();

    // 2. Abort in RX; mult_done during RX is ignored.
    s0 = start_cnt;
    exp_q.push_back(E_RX);
    bus.cs_n = 1'b0;
    tick();
    bus.mult_done = 1'b1;
    tick();
    bus.mult_done = 1'b0;
    check("t2_done_ignored", bus.state_dbg, ST_RX);
    pulses(3);
    exp_q.push_back(E_IDLE);
    bus.cs_n = 1'b1;
    tick();
    check("t2_abort_state", bus.state_dbg, ST_IDLE);
    check("t2_abort_outs", {bus.busy, bus.sr_mode}, 3'b000);
    repeat (3) tick();
    check("t2_no_start", start_cnt - s0, 0);

    // 3. cs_n rises on the same clk as the 8th RX pulse.
    s0 = start_cnt;
    exp_q.push_back(E_RX);
    bus.cs_n = 1'b0;
    tick();
    pulses(7);
    exp_q.push_back(E_IDLE);
    bus.sclk_pe = 1'b1;
    bus.cs_n    = 1'b1;
    tick();
    bus.sclk_pe = 1'b0;
    check("t3_abort_wins", bus.state_dbg, ST_IDLE);
    repeat (3) tick();
    check("t3_no_start", start_cnt - s0, 0);

    // 4. Spurious SCLK in WAIT; TX still needs the full 8 pulses.
    to_wait();
    pulses(4);
    check("t4_wait_hold", {5'b0, bus.state_dbg, bus.sr_mode}, {5'b0, ST_WAIT, 2'b00});
    done_to_tx();
    pulses(7);
    check("t4_tx_after7", bus.state_dbg, ST_TX);
    exp_q.push_back(E_DONE);
    bus.sclk_pe = 1'b1;
    tick();
    bus.sclk_pe = 1'b0;
    check("t4_done", bus.state_dbg, ST_DONE);
    exp_q.push_back(E_IDLE);
    bus.cs_n = 1'b1;
    tick();
    tick();

    // 5. Multiplier timeout.
`ifdef SPI_MULT_TIMEOUT_EN
    to_wait();
    repeat (MULT_TIMEOUT - 1) tick();
    check("t5_wait_before_to", {bus.state_dbg, bus.err_timeout}, {ST_WAIT, 1'b0});
    exp_q.push_back(E_ERR);
    tick();
    check("t5_err_state", bus.state_dbg, ST_ERR);
    check("t5_err_flag", bus.err_timeout, 1'b1);
    check("t5_err_miso", bus.miso_en, 1'b0);
    exp_q.push_back(E_IDLE_ERR);
    bus.cs_n = 1'b1;
    tick();
    check("t5_sticky_after_abort", bus.err_timeout, 1'b1);
    exp_q.push_back(E_RX);
    bus.cs_n = 1'b0;
    tick();
    check("t5_clear_on_rx", bus.err_timeout, 1'b0);
    exp_q.push_back(E_IDLE);
    bus.cs_n = 1'b1;
    tick();
    tick();
`else
    to_wait();
    repeat (1000) tick();
    check("t5_wait_forever", {bus.state_dbg, bus.err_timeout}, {ST_WAIT, 1'b0});
    exp_q.push_back(E_IDLE);
    bus.cs_n = 1'b1;
    tick();
    tick();
`endif

    // 6. Reset mid-TX, then a fresh frame must need all 8 pulses.
    to_wait();
    done_to_tx();
    pulses(3);
    exp_q.push_back(E_IDLE);
    rst_n    = 1'b0;
    bus.cs_n = 1'b1;
    tick();
    rst_n = 1'b1;
    check("t6_reset_outs", {bus.busy, bus.err_timeout, bus.miso_en, bus.mult_start, bus.sr_mode}, 6'b0);
    check("t6_reset_state", bus.state_dbg, ST_IDLE);
    exp_q.push_back(E_RX);
    bus.cs_n = 1'b0;
    tick();
    pulses(7);
    check("t6_bitcnt_cleared", bus.state_dbg, ST_RX);
    exp_q.push_back(E_START);
    bus.sclk_pe = 1'b1;
    tick();
    bus.sclk_pe = 1'b0;
    check("t6_start", bus.state_dbg, ST_START);
    exp_q.push_back(E_IDLE);
    bus.cs_n = 1'b1;
    tick();
    check("t6_abort_start", bus.state_dbg, ST_IDLE);
    repeat (3) tick();

    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
